// File: rtl/fp_rec_norm.sv
// Three-stage fixed-point normaliser feeding the reciprocal core: sign/abs, leading-one, shift/exponent.
// Optional divide-by-zero flag port dz is built when REC_NORM_DZ_EN is defined.
module fp_rec_norm #(
   parameter int WI = 4,
   parameter int WF = 4
) (
   input  logic                        CLK,
   input  logic                        nRST,
   input  logic                        CE,
   input  logic                        din_valid,
   input  logic [WI+WF-1:0]            din,
   output logic                        dout_valid,
   output logic                        sign,
   output logic [WI+WF-1:0]            mant,
   output logic [$clog2(WI+WF)+1:0]    expo
`ifdef REC_NORM_DZ_EN
   ,
   output logic                        dz
`endif
);

   localparam int WL = WI + WF;
   localparam int EW = $clog2(WL) + 2;
   localparam int PW = ($clog2(WL) > 0) ? $clog2(WL) : 1;

   // stage 1: sign and magnitude
   logic          v1, s1;
   logic [WL-1:0] abs1;
   // stage 2: leading-one position
   logic          v2, s2, zero2;
   logic [WL-1:0] abs2;
   logic [PW-1:0] p2;

   logic [WL-1:0] abs_n;
   logic [PW-1:0] p_n;
   logic          zero_n;
   logic [PW-1:0] shamt;
   logic [WL-1:0] mant_n;
   logic [EW-1:0] expo_n;

   // the most negative input negates onto itself, which read unsigned is exactly 2^(WL-1)
   always_comb begin
      abs_n = din[WL-1] ? ('0 - din) : din;
   end

   always_comb begin
      p_n = '0;
      for (int unsigned i = 0; i < WL; i++) begin
         if (abs1[i]) p_n = PW'(i);
      end
      zero_n = (abs1 == '0);
   end

   always_comb begin
      shamt  = PW'(WL - 1) - p2;
      mant_n = zero2 ? '0 : (abs2 << shamt);
      expo_n = EW'(p2) - EW'(WF);
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         v1    <= 1'b0;
         s1    <= 1'b0;
         abs1  <= '0;
         v2    <= 1'b0;
         s2    <= 1'b0;
         zero2 <= 1'b0;
         abs2  <= '0;
         p2    <= '0;
      end else if (CE) begin
         v1    <= din_valid;
         s1    <= din[WL-1];
         abs1  <= abs_n;
         v2    <= v1;
         s2    <= s1;
         zero2 <= zero_n;
         abs2  <= abs1;
         p2    <= p_n;
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         dout_valid <= 1'b0;
         sign       <= 1'b0;
         mant       <= '0;
         expo       <= '0;
      end else if (CE) begin
         dout_valid <= v2;
         sign       <= s2;
         mant       <= mant_n;
         expo       <= expo_n;
      end
   end

`ifdef REC_NORM_DZ_EN
   always_ff @(posedge CLK) begin
      if (!nRST)   dz <= 1'b0;
      else if (CE) dz <= v2 & zero2;
   end
`endif

endmodule

// File: tb/tb_fp_rec_norm.sv
// Self-checking bench for fp_rec_norm: arithmetic reference model plus directed and random stimulus.
// Build with REC_NORM_DZ_EN to also check the divide-by-zero flag.
module tb_fp_rec_norm;

   localparam int WI = 4;
   localparam int WF = 4;
   localparam int WL = WI + WF;
   localparam int EW = $clog2(WL) + 2;

   logic          CLK = 1'b0;
   logic          nRST = 1'b0;
   logic          CE = 1'b0;
   logic          din_valid = 1'b0;
   logic [WL-1:0] din = '0;
   logic          dout_valid, sign;
   logic [WL-1:0] mant;
   logic [EW-1:0] expo;
`ifdef REC_NORM_DZ_EN
   logic          dz;
`endif

   fp_rec_norm #(.WI(WI), .WF(WF)) dut (
      .CLK(CLK), .nRST(nRST), .CE(CE), .din_valid(din_valid), .din(din),
      .dout_valid(dout_valid), .sign(sign), .mant(mant), .expo(expo)
`ifdef REC_NORM_DZ_EN
      , .dz(dz)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct {
      bit          v;
      bit          s;
      logic [WL-1:0] m;
      int          e;
      bit          dz;
   } out_t;

   typedef struct {
      bit          rst;
      bit          v;
      logic [WL-1:0] d;
   } stg_t;

   int   n_pass = 0;
   int   n_total = 0;
   bit   model_ok = 1'b0;
   stg_t pipe [3];

   // value = signed integer / 2^WF; mantissa holds |value| scaled so its top bit is set
   function automatic out_t ref_norm(input logic [WL-1:0] d, input bit v);
      out_t   r;
      longint val;
      longint mag;
      int     p;
      val = longint'(d);
      if (d[WL-1]) val = val - (longint'(1) << WL);
      mag  = (val < 0) ? -val : val;
      r.v  = v;
      r.s  = (val < 0);
      r.dz = 1'b0;
      if (mag == 0) begin
         r.m  = '0;
         r.e  = -WF;
         r.dz = v;
      end else begin
         p = 0;
         while ((mag >> (p + 1)) != 0) p++;
         r.m = WL'(mag << (WL - 1 - p));
         r.e = p - WF;
      end
      return r;
   endfunction

   function automatic out_t model_out();
      out_t z;
      if (pipe[2].rst) begin
         z.v = 0; z.s = 0; z.m = '0; z.e = 0; z.dz = 0;
         return z;
      end
      return ref_norm(pipe[2].d, pipe[2].v);
   endfunction

   function automatic stg_t adv(input stg_t x);
      stg_t y;
      y = x;
      if (x.rst) begin
         y.rst = 0; y.v = 0; y.d = '0;
      end
      return y;
   endfunction

   function automatic string fmt(input out_t o);
      return $sformatf("v=%0d s=%0d m=%h e=%0d dz=%0d", o.v, o.s, o.m, o.e, o.dz);
   endfunction

   function automatic out_t dut_out();
      out_t a;
      a.v = dout_valid; a.s = sign; a.m = mant; a.e = int'($signed(expo));
`ifdef REC_NORM_DZ_EN
      a.dz = dz;
`else
      a.dz = 1'b0;
`endif
      return a;
   endfunction

   function automatic bit same(input out_t a, input out_t b);
      bit ok;
      ok = (a.v == b.v) && (a.s == b.s) && (a.m == b.m) && (a.e == b.e);
`ifdef REC_NORM_DZ_EN
      ok = ok && (a.dz == b.dz);
`endif
      return ok;
   endfunction

   task automatic check(input string name, input out_t got, input out_t need);
      n_total++;
      if (same(got, need)) n_pass++;
      else $display("FAIL %s: got %s, need %s", name, fmt(got), fmt(need));
   endtask

   // reference pipeline advances on the same enabled edges the DUT should
   always @(posedge CLK) begin
      if (!nRST) begin
         for (int i = 0; i < 3; i++) pipe[i] = '{rst: 1'b1, v: 1'b0, d: '0};
         model_ok = 1'b1;
      end else if (CE && model_ok) begin
         pipe[2] = adv(pipe[1]);
         pipe[1] = adv(pipe[0]);
         pipe[0] = '{rst: 1'b0, v: din_valid, d: din};
      end
   end

   always @(negedge CLK) begin
      if (model_ok) check($sformatf("cycle@%0t", $time), dut_out(), model_out());
   end

   task automatic drive(input bit r, input bit c, input bit v, input logic [WL-1:0] d);
      @(posedge CLK);
      #2;
      nRST = r; CE = c; din_valid = v; din = d;
   endtask

   function automatic out_t lit(input bit v, input bit s, input logic [WL-1:0] m,
                                input int e, input bit z);
      out_t o;
      o.v = v; o.s = s; o.m = m; o.e = e; o.dz = z;
      return o;
   endfunction

   initial begin
      // model pinned against hand-computed values
      check("model_1p5",   ref_norm(8'h18, 1'b1), lit(1, 0, 8'hC0,  0, 0));
      check("model_m0p375", ref_norm(8'hFA, 1'b1), lit(1, 1, 8'hC0, -2, 0));
      check("model_m8",    ref_norm(8'h80, 1'b1), lit(1, 1, 8'h80,  3, 0));
      check("model_lsb",   ref_norm(8'h01, 1'b1), lit(1, 0, 8'h80, -4, 0));
      check("model_zero",  ref_norm(8'h00, 1'b1), lit(1, 0, 8'h00, -4, 1));

      drive(0, 1, 0, '0);
      drive(1, 1, 0, '0);
      @(negedge CLK);
      check("reset_state", dut_out(), lit(0, 0, '0, 0, 0));

      // 1.5 appears after exactly three enabled edges
      drive(1, 1, 1, 8'h18);
      drive(1, 1, 0, 8'h00);
      drive(1, 1, 0, 8'h00);
      drive(1, 1, 0, 8'h00);
      @(negedge CLK);
      check("lat3_1p5", dut_out(), lit(1, 0, 8'hC0, 0, 0));

      // back-to-back stream with CE low for two cycles mid-stream
      drive(1, 1, 1, 8'h18);
      drive(1, 1, 1, 8'hFA);
      drive(1, 0, 1, 8'h55);
      drive(1, 0, 0, 8'h33);
      drive(1, 1, 1, 8'h80);
      drive(1, 1, 0, 8'h00);
      drive(1, 1, 0, 8'h00);
      drive(1, 1, 0, 8'h00);

      drive(1, 1, 1, 8'h01);
      drive(1, 1, 1, 8'h00);
      drive(1, 1, 0, 8'h00);
      drive(1, 1, 0, 8'h00);
      @(negedge CLK);
      check("lsb", dut_out(), lit(1, 0, 8'h80, -4, 0));
      drive(1, 1, 0, 8'h00);
      @(negedge CLK);
      check("zero", dut_out(), lit(1, 0, 8'h00, -4, 1));

      // reset with two samples in flight discards both
      drive(1, 1, 1, 8'h18);
      drive(1, 1, 1, 8'hFA);
      drive(0, 1, 1, 8'h80);
      drive(1, 1, 0, 8'h00);
      @(negedge CLK);
      check("rst_flush", dut_out(), lit(0, 0, '0, 0, 0));
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 0, 8'h00);
         @(negedge CLK);
         n_total++;
         if (dout_valid == 1'b0) n_pass++;
         else $display("FAIL rst_discard%0d: got dout_valid=%0d, need 0", i, dout_valid);
      end

      for (int i = 0; i < 600; i++) begin
         logic [WL-1:0] d;
         int unsigned   k;
         k = $urandom_range(0, 9);
         case (k)
            0:       d = '0;
            1:       d = {1'b1, {(WL-1){1'b0}}};
            2:       d = '1;
            3:       d = WL'(1);
            default: d = WL'($urandom);
         endcase
         drive($urandom_range(0, 39) != 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 3) != 0, d);
      end
      drive(1, 1, 0, '0);
      drive(1, 1, 0, '0);
      drive(1, 1, 0, '0);
      drive(1, 1, 0, '0);
      @(negedge CLK);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
